// File: rtl/ps2_transceiver.sv
// ps2_transceiver: bidirectional PS/2 PHY with input sync/filter, RX FIFO and host-to-device TX.
// Rev 1.0 - initial release.
`default_nettype none

module ps2_transceiver #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 8,
  parameter int FRAME_TO_US = 2000,
  parameter int INHIBIT_US  = 120,
  parameter int TX_TO_US    = 15000
) (
  input  logic       clkin,
  input  logic       rst,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_err,
  output logic       rx_overflow,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       device_clk,
  input  logic       device_dat,
  output logic       device_clk_oe,
  output logic       device_dat_oe
);

  localparam int          CYC_PER_US   = CLK_HZ / 1_000_000;
  localparam logic [31:0] FRAME_TO_CYC = 32'(CYC_PER_US * FRAME_TO_US);
  localparam logic [31:0] INHIBIT_CYC  = 32'(CYC_PER_US * INHIBIT_US);
  localparam logic [31:0] TX_TO_CYC    = 32'(CYC_PER_US * TX_TO_US);
  localparam int          FW           = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FILT_MAX   = FW'(FILTER_LEN - 1);
  localparam int          AW           = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C      = (AW+1)'(FIFO_DEPTH);

  // ---------------- input synchronisers and glitch filters (bit 0 = clk, bit 1 = dat)
  logic [1:0]    sync1_q, sync2_q, filt_q;
  logic [FW-1:0] fcnt_q [2];
  logic          filt_clk_prev_q;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      sync1_q         <= 2'b11;
      sync2_q         <= 2'b11;
      filt_q          <= 2'b11;
      filt_clk_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      sync1_q         <= {device_dat, device_clk};
      sync2_q         <= sync1_q;
      filt_clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        // The filtered line only follows after FILTER_LEN consecutive differing samples.
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FILT_MAX) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic w_event, w_dat;
  assign w_event = filt_clk_prev_q & ~filt_q[0];
  assign w_dat   = filt_q[1];

  // ---------------- protocol FSM
  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_TX_INHIBIT, S_TX_REQ, S_TX_BITS, S_TX_ACK
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [8:0]  tx_shift_q, tx_shift_d;
  logic [31:0] timer_q, timer_d;
  logic        par_ok_q, par_ok_d;
  logic        clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic        push_q, push_d;
  logic        rx_err_q, rx_err_d, tx_done_q, tx_done_d, tx_err_q, tx_err_d;
  logic        w_tx_ready;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_shift_q <= '0;
      timer_q    <= '0;
      par_ok_q   <= 1'b0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      push_q     <= 1'b0;
      rx_err_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      timer_q    <= timer_d;
      par_ok_q   <= par_ok_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      push_q     <= push_d;
      rx_err_q   <= rx_err_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    timer_d    = timer_q + 32'd1;
    par_ok_d   = par_ok_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    push_d     = 1'b0;
    rx_err_d   = 1'b0;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    w_tx_ready = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        timer_d  = '0;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        // A start bit beats a simultaneous TX request; the request stays pending.
        if (w_event && !w_dat) begin
          state_d   = S_RX;
          bit_cnt_d = '0;
        end else begin
          w_tx_ready = 1'b1;
          if (tx_valid) begin
            state_d    = S_TX_INHIBIT;
            tx_shift_d = {~^tx_data, tx_data};
            clk_oe_d   = 1'b1;
          end
        end
      end

      S_RX: begin
        if (w_event) begin
          timer_d   = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8) begin
            shift_d = {w_dat, shift_q[7:1]};
          end else if (bit_cnt_q == 4'd8) begin
            par_ok_d = ^{shift_q, w_dat};
          end else begin
            state_d = S_IDLE;
            if (w_dat && par_ok_q) push_d   = 1'b1;
            else                   rx_err_d = 1'b1;
          end
        end else if (timer_q >= FRAME_TO_CYC - 32'd1) begin
          rx_err_d = 1'b1;
          state_d  = S_IDLE;
        end
      end

      S_TX_INHIBIT: begin
        clk_oe_d = 1'b1;
        if (timer_q >= INHIBIT_CYC - 32'd1) begin
          clk_oe_d  = 1'b0;
          dat_oe_d  = 1'b1;
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = S_TX_REQ;
        end
      end

      S_TX_REQ, S_TX_BITS: begin
        if (w_event) begin
          state_d = S_TX_BITS;
          if (bit_cnt_q < 4'd9) begin
            dat_oe_d   = ~tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[8:1]};
            bit_cnt_d  = bit_cnt_q + 4'd1;
          end else begin
            dat_oe_d = 1'b0;
            state_d  = S_TX_ACK;
          end
        end else if (timer_q >= TX_TO_CYC - 32'd1) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          tx_err_d = 1'b1;
          state_d  = S_IDLE;
        end
      end

      S_TX_ACK: begin
        if (w_event || timer_q >= TX_TO_CYC - 32'd1) begin
          if (w_event && !w_dat) tx_done_d = 1'b1;
          else                   tx_err_d  = 1'b1;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- RX FIFO
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        w_full, w_pop, w_push, ovf_q;

  assign w_full = ((wr_q - rd_q) == DEPTH_C);
  assign w_pop  = rx_valid & rx_ready;
  assign w_push = push_q & (~w_full | w_pop);

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (w_push) wr_q <= wr_q + 1'b1;
      if (w_pop)  rd_q <= rd_q + 1'b1;
      ovf_q <= push_q & w_full & ~w_pop;
    end
  end

  // Frame data stays in shift_q until the next frame begins, so it is written the cycle after the stop bit.
  always_ff @(posedge clkin) begin
    if (w_push) mem_q[wr_q[AW-1:0]] <= shift_q;
  end

  assign rx_data       = mem_q[rd_q[AW-1:0]];
  assign rx_valid      = (wr_q != rd_q);
  assign rx_err        = rx_err_q;
  assign rx_overflow   = ovf_q;
  assign tx_ready      = w_tx_ready;
  assign tx_done       = tx_done_q;
  assign tx_err        = tx_err_q;
  assign device_clk_oe = clk_oe_q;
  assign device_dat_oe = dat_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_transceiver.sv
// tb_ps2_transceiver: directed + randomized checks of the PS/2 PHY against a queue-based device/host model.
// Rev 1.0 - initial release.
`default_nettype none

module tb_ps2_transceiver;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, rx_err, rx_overflow;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_done, tx_err;
  logic       dev_clk_drv, dev_dat_drv;
  logic       clk_oe, dat_oe;
  logic       device_clk, device_dat;

  always #5 clk = ~clk;

  // Open-drain wiring: either side can pull a line low.
  assign device_clk = dev_clk_drv & ~clk_oe;
  assign device_dat = dev_dat_drv & ~dat_oe;

  ps2_transceiver #(
    .CLK_HZ(1_000_000), .FIFO_DEPTH(DEPTH), .FILTER_LEN(8),
    .FRAME_TO_US(2000), .INHIBIT_US(120), .TX_TO_US(15000)
  ) dut (
    .clkin(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_err(rx_err), .rx_overflow(rx_overflow),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_err(tx_err),
    .device_clk(device_clk), .device_dat(device_dat),
    .device_clk_oe(clk_oe), .device_dat_oe(dat_oe)
  );

  int tests = 0, fails = 0;
  int n_rxerr = 0, n_ovf = 0, n_done = 0, n_txerr = 0;

  always @(negedge clk) begin
    if (rx_err)      n_rxerr++;
    if (rx_overflow) n_ovf++;
    if (tx_done)     n_done++;
    if (tx_err)      n_txerr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
  endfunction

  // One device-driven bit: data set up, clock low 40 us, clock high (12.5 kHz at 1 MHz clkin).
  task automatic dev_bit(input logic b);
    dev_dat_drv = b;
    repeat (20) @(posedge clk);
    dev_clk_drv = 1'b0;
    repeat (40) @(posedge clk);
    dev_clk_drv = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    dev_bit(1'b0);
    for (int i = 0; i < 8; i++) dev_bit(d[i]);
    dev_bit(odd_par(d) ^ par_flip);
    dev_bit(stop);
    dev_dat_drv = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp});
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // Device side of a host command: measures inhibit, clocks out 10 bits, optionally acks.
  task automatic host_cmd(input logic [7:0] d, input logic ack);
    logic [9:0] bits;
    int low, d0, e0;
    d0 = n_done;
    e0 = n_txerr;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    check("tx_ready_idle", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
    low = 0;
    while (clk_oe && low < 1000) begin
      @(negedge clk);
      low++;
    end
    check("inhibit_len", low, 32'd120);
    check("start_bit", {31'd0, dat_oe}, 32'd1);
    repeat (20) @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      repeat (20) @(posedge clk);
      dev_clk_drv = 1'b0;
      repeat (40) @(posedge clk);
      bits[k] = device_dat;
      dev_clk_drv = 1'b1;
    end
    repeat (20) @(posedge clk);
    dev_dat_drv = ack ? 1'b0 : 1'b1;
    repeat (20) @(posedge clk);
    dev_clk_drv = 1'b0;
    repeat (40) @(posedge clk);
    dev_clk_drv = 1'b1;
    dev_dat_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("tx_bits", {24'd0, bits[7:0]}, {24'd0, d});
    check("tx_parity", {31'd0, bits[8]}, {31'd0, odd_par(d)});
    check("tx_stop", {31'd0, bits[9]}, 32'd1);
    check("tx_done_cnt", n_done - d0, ack ? 32'd1 : 32'd0);
    check("tx_err_cnt", n_txerr - e0, ack ? 32'd0 : 32'd1);
    check("tx_lines_rel", {30'd0, clk_oe, dat_oe}, 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] b;
    int e0, o0, exp_ovf, cyc;

    rst = 1'b1; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk_drv = 1'b1; dev_dat_drv = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_oe", {30'd0, clk_oe, dat_oe}, 32'd0);
    check("rst_pulses", {28'd0, rx_err, rx_overflow, tx_done, tx_err}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Basic receive and pop
    send_frame(8'h1C, 1'b0, 1'b1);
    pop_expect("rx_1c", 8'h1C);
    check("rx_empty_after_pop", {31'd0, rx_valid}, 32'd0);

    // Parity error, stop-bit error, then recovery
    e0 = n_rxerr;
    send_frame(8'hF0, 1'b1, 1'b1);
    check("par_err_pulse", n_rxerr - e0, 32'd1);
    check("par_err_empty", {31'd0, rx_valid}, 32'd0);
    send_frame(8'h33, 1'b0, 1'b0);
    check("stop_err_pulse", n_rxerr - e0, 32'd2);
    check("stop_err_empty", {31'd0, rx_valid}, 32'd0);
    send_frame(8'h12, 1'b0, 1'b1);
    pop_expect("rx_12", 8'h12);

    // Random bytes into a stalled consumer: queue model decides storage vs overflow
    o0 = n_ovf;
    exp_ovf = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b0, 1'b1);
      if (q.size() < DEPTH) q.push_back(b);
      else exp_ovf++;
    end
    check("overflow_cnt", n_ovf - o0, exp_ovf);
    while (q.size() > 0) pop_expect("fifo_order", q.pop_front());
    check("fifo_drained", {31'd0, rx_valid}, 32'd0);

    // Frame stall: start + 4 bits, then silence beyond the frame timeout
    e0 = n_rxerr;
    dev_bit(1'b0);
    for (int i = 0; i < 4; i++) dev_bit(1'($urandom));
    dev_dat_drv = 1'b1;
    repeat (2100) @(negedge clk);
    check("frame_timeout", n_rxerr - e0, 32'd1);
    send_frame(8'h5A, 1'b0, 1'b1);
    pop_expect("rx_5a", 8'h5A);

    // Host-to-device with ack, then a random byte without ack
    host_cmd(8'hED, 1'b1);
    host_cmd(8'($urandom), 1'b0);

    // Device never clocks after the request: TX timeout
    e0 = n_txerr;
    @(negedge clk);
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    cyc = 0;
    while (n_txerr == e0 && cyc < 16000) begin
      @(negedge clk);
      cyc++;
    end
    check("tx_timeout_pulse", n_txerr - e0, 32'd1);
    check("tx_timeout_rel", {30'd0, clk_oe, dat_oe}, 32'd0);

    // Short clock glitch with data low while idle: filter must hide it
    dev_dat_drv = 1'b0;
    repeat (20) @(negedge clk);
    dev_clk_drv = 1'b0;
    repeat (3) @(negedge clk);
    dev_clk_drv = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_idle", {31'd0, tx_ready}, 32'd1);
    dev_dat_drv = 1'b1;
    repeat (30) @(negedge clk);

    // Asynchronous reset mid-TX with a byte sitting in the FIFO
    send_frame(8'h77, 1'b0, 1'b1);
    @(negedge clk);
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_clk_oe", {31'd0, clk_oe}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_oe", {30'd0, clk_oe, dat_oe}, 32'd0);
    check("async_rst_fifo", {31'd0, rx_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_idle", {31'd0, tx_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
